// File: rtl/afp_mult_arbiter.sv
// ----------------------------------------------------------------------------
// afp_mult_arbiter
//
// Shares one combinational 4-bit AFP multiplier among N requesters.
// A round-robin arbiter grants at most one requester per cycle into an
// operand register (S1). The shared multiplier evaluates the S1 operands, and
// its unnormalized product fields are captured with the requester tag in a
// result register (S2). S2 drives a single valid/ready output port with full
// backpressure. At most two operations are buffered.
//
// AFP operand packing (4 bits): [3] sign, [2:1] offset, [0] fraction bit.
// Offsets 0..2 are normal and carry a hidden leading one, so the mantissa is
// {1, f}. Offset 3 is the denormal code: there is no hidden one, and the
// fraction bit takes the leading position, so the mantissa is {f, 0}.
//
// Ports (afp_mult_arbiter):
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high reset
//   req_valid   in   N     per-requester operand-pair valid
//   req_x       in   4*N   packed operand x, requester i in [4i+3:4i]
//   req_y       in   4*N   packed operand y, requester i in [4i+3:4i]
//   req_ready   out  N     one-hot (or zero) grant, accepted at this edge
//   out_valid   out  1     result register holds a valid result
//   out_ready   in   1     downstream takes the result at this edge
//   out_pm      out  4     product mantissa (unnormalized)
//   out_po      out  3     product offset, sum of the operand offsets
//   out_ps      out  1     product sign
//   out_tag     out  TW    index of the requester that issued the result
//   done_count  out  CW    results consumed downstream, wrapping
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// afp_multiplier: purely combinational product of two packed AFP operands.
//   x_i, y_i  in   packed operands
//   pm_o      out  mantissa product (2b x 2b -> 4b)
//   po_o      out  offset sum
//   ps_o      out  sign (xor)
// ----------------------------------------------------------------------------
module afp_multiplier (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    output logic [3:0] pm_o,
    output logic [2:0] po_o,
    output logic       ps_o
);

    logic [1:0] mant_x;
    logic [1:0] mant_y;

    // Offset code 3 drops the hidden one and promotes the fraction bit.
    always_comb begin
        mant_x = (x_i[2:1] == 2'b11) ? {x_i[0], 1'b0} : {1'b1, x_i[0]};
        mant_y = (y_i[2:1] == 2'b11) ? {y_i[0], 1'b0} : {1'b1, y_i[0]};
        pm_o   = {2'b00, mant_x} * {2'b00, mant_y};
        po_o   = {1'b0, x_i[2:1]} + {1'b0, y_i[2:1]};
        ps_o   = x_i[3] ^ y_i[3];
    end

endmodule

module afp_mult_arbiter #(
    parameter int N  = 4,
    parameter int TW = $clog2(N),
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [4*N-1:0]  req_x,
    input  logic [4*N-1:0]  req_y,
    output logic [N-1:0]    req_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_pm,
    output logic [2:0]      out_po,
    output logic            out_ps,
    output logic [TW-1:0]   out_tag,
    output logic [CW-1:0]   done_count
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TW-1:0] ptr_q,      ptr_d;

    logic          s1_valid_q, s1_valid_d;
    logic [3:0]    s1_x_q,     s1_x_d;
    logic [3:0]    s1_y_q,     s1_y_d;
    logic [TW-1:0] s1_tag_q,   s1_tag_d;

    logic          s2_valid_q, s2_valid_d;
    logic [3:0]    s2_pm_q,    s2_pm_d;
    logic [2:0]    s2_po_q,    s2_po_d;
    logic          s2_ps_q,    s2_ps_d;
    logic [TW-1:0] s2_tag_q,   s2_tag_d;

    logic [CW-1:0] done_q,     done_d;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic out_fire;
    logic s1_adv;
    logic s1_load_ok;

    always_comb begin
        out_fire   = s2_valid_q && out_ready;
        s1_adv     = s1_valid_q && (!s2_valid_q || out_ready);
        // Reset masks the grant so req_ready reads zero while it is held.
        s1_load_ok = !reset && (!s1_valid_q || s1_adv);
    end

    // ------------------------------------------------------------------
    // Round-robin search: first set req_valid bit at or after ptr_q
    // ------------------------------------------------------------------
    function automatic logic [TW-1:0] rr_index(input logic [TW-1:0] base,
                                               input int            k);
        int s;
        s = (int'(base) + k) % N;
        return TW'(s);
    endfunction

    logic [N-1:0]  gnt;
    logic          gnt_found;
    logic [TW-1:0] gnt_idx;
    logic [TW-1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = rr_index(ptr_q, k);
            if (s1_load_ok && !gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Operand mux driven by the one-hot grant.
    logic [3:0] gnt_x;
    logic [3:0] gnt_y;

    always_comb begin
        gnt_x = '0;
        gnt_y = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_x = req_x[i*4 +: 4];
                gnt_y = req_y[i*4 +: 4];
            end
        end
    end

    assign req_ready = gnt;

    // ------------------------------------------------------------------
    // Shared multiplier, fed from S1
    // ------------------------------------------------------------------
    logic [3:0] mul_pm;
    logic [2:0] mul_po;
    logic       mul_ps;

    afp_multiplier u_mul (
        .x_i  (s1_x_q),
        .y_i  (s1_y_q),
        .pm_o (mul_pm),
        .po_o (mul_po),
        .ps_o (mul_ps)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_found) begin
            ptr_d = (gnt_idx == TW'(N - 1)) ? '0 : gnt_idx + TW'(1);
        end
    end

    // A grant in the same cycle that S1 advances refills it, so the
    // valid bit only falls when S1 empties without a replacement.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_tag_d   = s1_tag_q;
        if (gnt_found) begin
            s1_valid_d = 1'b1;
            s1_x_d     = gnt_x;
            s1_y_d     = gnt_y;
            s1_tag_d   = gnt_idx;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_pm_d    = s2_pm_q;
        s2_po_d    = s2_po_q;
        s2_ps_d    = s2_ps_q;
        s2_tag_d   = s2_tag_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_pm_d    = mul_pm;
            s2_po_d    = mul_po;
            s2_ps_d    = mul_ps;
            s2_tag_d   = s1_tag_q;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        done_d = done_q;
        if (out_fire) begin
            done_d = done_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_pm_q    <= '0;
            s2_po_q    <= '0;
            s2_ps_q    <= 1'b0;
            s2_tag_q   <= '0;
            done_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_pm_q    <= s2_pm_d;
            s2_po_q    <= s2_po_d;
            s2_ps_q    <= s2_ps_d;
            s2_tag_q   <= s2_tag_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid  = s2_valid_q;
    assign out_pm     = s2_pm_q;
    assign out_po     = s2_po_q;
    assign out_ps     = s2_ps_q;
    assign out_tag    = s2_tag_q;
    assign done_count = done_q;

endmodule

// File: tb/tb_afp_mult_arbiter.sv
// ----------------------------------------------------------------------------
// tb_afp_mult_arbiter
//
// Bench for afp_mult_arbiter with N=4 and a 2-bit done counter so the wrap
// is exercised. A transaction-level model (round-robin pointer, FIFO of
// in-flight operations with capacity two, consumed-count) predicts grants,
// out_valid and done_count every cycle; predicted results go into a
// scoreboard queue that a monitor pops whenever the DUT presents a result.
// ----------------------------------------------------------------------------
module tb_afp_mult_arbiter;

    localparam int N  = 4;
    localparam int TW = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [4*N-1:0] req_x;
    logic [4*N-1:0] req_y;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_pm;
    logic [2:0]    out_po;
    logic          out_ps;
    logic [TW-1:0] out_tag;
    logic [CW-1:0] done_count;

    always #5 clk = ~clk;

    afp_mult_arbiter #(.N(N), .TW(TW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pm     (out_pm),
        .out_po     (out_po),
        .out_ps     (out_ps),
        .out_tag    (out_tag),
        .done_count (done_count)
    );

    // ------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------
    function automatic logic [7:0] afp_ref(input logic [3:0] x, input logic [3:0] y);
        int mx, my, pm, po;
        mx = (x[2:1] == 2'b11) ? 2 * int'(x[0]) : 2 + int'(x[0]);
        my = (y[2:1] == 2'b11) ? 2 * int'(y[0]) : 2 + int'(y[0]);
        pm = mx * my;
        po = int'(x[2:1]) + int'(y[2:1]);
        return {4'(pm), 3'(po), x[3] ^ y[3]};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Model state and scoreboard
    // ------------------------------------------------------------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [9:0]  exp_q[$];      // {pm, po, ps, tag}
    int          ages[$];       // edges each in-flight op has been held
    int          m_ptr = 0;
    int          m_done = 0;
    bit          chk_en = 0;
    bit          final_chk = 0;
    bit          pin_v[N];
    logic [7:0]  pin_val[N];

    bit          m_consume;
    bit          m_can_load;
    int          m_g;
    logic [N-1:0] m_pred;
    bit          m_vis;
    logic [9:0]  m_entry;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            m_vis      = (ages.size() > 0) && (ages[0] >= 1);
            m_consume  = m_vis && out_ready;
            m_can_load = (ages.size() < 2) || m_consume;
            m_g        = (reset || !m_can_load) ? -1 : rr_pick(req_valid, m_ptr);
            m_pred     = (m_g >= 0) ? N'(1 << m_g) : '0;

            chk("req_ready", 16'(req_ready), 16'(m_pred));
            chk("out_valid", 16'(out_valid), 16'(m_vis));
            chk("done_count", 16'(done_count), 16'(m_done));

            // Monitor: compare every presented result with the scoreboard head.
            if (!reset && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 16'({out_pm, out_po, out_ps, out_tag}), 16'h0fff);
                end else begin
                    chk("result", 16'({out_pm, out_po, out_ps, out_tag}), 16'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end

            if (final_chk) begin
                chk("sb_drain", 16'(exp_q.size()), 16'd0);
            end

            // Advance the model across the coming edge.
            if (reset) begin
                exp_q.delete();
                ages.delete();
                m_ptr  = 0;
                m_done = 0;
            end else begin
                if (m_consume) begin
                    void'(ages.pop_front());
                    m_done = (m_done + 1) % (1 << CW);
                end
                foreach (ages[i]) ages[i] = ages[i] + 1;
                if (m_g >= 0) begin
                    m_entry = pin_v[m_g] ? {pin_val[m_g], 2'(m_g)}
                                         : {afp_ref(req_x[m_g*4 +: 4], req_y[m_g*4 +: 4]), 2'(m_g)};
                    exp_q.push_back(m_entry);
                    ages.push_back(0);
                    m_ptr = (m_g + 1) % N;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] pv);
        pin_v[r]        = 1'b1;
        pin_val[r]      = pv;
        req_x[r*4 +: 4] = x;
        req_y[r*4 +: 4] = y;
        req_valid       = N'(1 << r);
        tick();
        req_valid       = '0;
        pin_v[r]        = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        tick();
        reset     = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            pin_v[i]   = 1'b0;
            pin_val[i] = '0;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Directed operand cases with fixed expected fields {pm, po, ps}.
        send(0, 4'b0010, 4'b0011, {4'b0110, 3'b010, 1'b0});
        send(2, 4'b1111, 4'b0001, {4'b0110, 3'b011, 1'b1});
        send(1, 4'b0001, 4'b0001, {4'b1001, 3'b000, 1'b0});

        // Round-robin with all requesters, then with requesters 1 and 3.
        do_reset();
        req_x     = 16'h3a52;
        req_y     = 16'h7c19;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        repeat (6) tick();
        req_valid = 4'b1010;
        repeat (4) tick();
        req_valid = '0;
        repeat (3) tick();

        // Backpressure: two grants, then stall; release and drain.
        out_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (6) tick();
        req_valid = '0;
        out_ready = 1'b1;
        repeat (4) tick();

        // Simultaneous consume / advance / refill with a full pipe.
        out_ready = 1'b0;
        req_valid = 4'b0110;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset with both stages full; first grant afterwards goes to 0.
        out_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        repeat (3) tick();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            req_x     = 16'($urandom);
            req_y     = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        req_valid = '0;
        out_ready = 1'b1;
        repeat (5) tick();
        final_chk = 1'b1;
        tick();
        final_chk = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/afp_mult_arbiter.md
# afp_mult_arbiter

Round-robin arbiter and two-stage pipeline wrapper that shares one 4-bit AFP multiplier datapath (`afp_multiplier`) among N requesters. Each requester presents a pair of packed 4-bit AFP operands with a valid/ready handshake. The block registers the granted operands, evaluates the shared combinational multiplier, and registers the unnormalized product fields (mantissa, offset, sign) with the requester's tag. Downstream consumers take results through a single valid/ready output port with full backpressure.

## Interface

Parameters:

- `N`, default 4: number of requesters, at least 2.
- `TW`, default `$clog2(N)`: tag width.
- `CW`, default 8: width of the completed-operation counter.

Ports (clock and reset first):

- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req_valid`, input, N: bit i asserts that requester i has an operand pair.
- `req_x`, input, 4*N: packed AFP operand x for requester i, in bits `[4i+3:4i]`.
- `req_y`, input, 4*N: packed AFP operand y for requester i, in bits `[4i+3:4i]`.
- `req_ready`, output, N: one-hot or zero grant. Bit i high means requester i's pair is accepted at this edge.
- `out_valid`, output, 1: result register holds a valid result.
- `out_ready`, input, 1: downstream accepts the result at this edge.
- `out_pm`, output, 4: product mantissa.
- `out_po`, output, 3: product offset, the sum of operand offsets.
- `out_ps`, output, 1: product sign.
- `out_tag`, output, TW: index of the requester that issued this result.
- `done_count`, output, CW: number of results consumed downstream, wrapping.

## Operation

- **Stage S1 (operand register).** Holds `s1_valid`, x, y and tag.
  - Can load when `!s1_valid` or S1 advances this cycle.
  - When S1 can load and at least one `req_valid` bit is set, exactly one requester is granted.
  - The granted requester is the first set bit found searching from `ptr` upward, modulo N.
  - `req_ready` equals this grant. It is combinational from `req_valid`, `ptr`, and the stage state. A requester must not make `req_valid` depend on `req_ready`.
  - On a grant to requester g: `ptr` becomes `(g+1) mod N`. When g = N-1, `ptr` wraps to 0.
  - With no grant, `ptr` holds.
  - If S1 cannot load, every `req_ready` bit is 0 and `ptr` holds.
- **Shared datapath.** One `afp_multiplier` instance is fed from the S1 x and y registers. It is purely combinational.
- **Stage S2 (result register).** Holds `s2_valid`, pm, po, ps and tag.
  - Loads from the multiplier output and the S1 tag when `s1_valid` and (`!s2_valid` or `out_ready`).
  - S1 advancing clears `s1_valid`, unless a new grant refills S1 in the same cycle.
  - `s2_valid` clears on `out_valid && out_ready` when S1 is not advancing.
- **Outputs.** `out_valid` equals `s2_valid`. The result outputs are driven directly from the S2 registers.
- **Stability under backpressure.** While `out_valid && !out_ready`, all S2 outputs remain stable. S1 also holds if it is occupied.
- **Counter.** `done_count` increments by 1 on each `out_valid && out_ready` edge and wraps from 2^CW-1 to 0.
- **Result format.** No normalization or rounding is done here. `out_pm`, `out_po` and `out_ps` are exactly the multiplier outputs for the stored operands.

## Timing

- **Reset values** (on `reset` high at an edge):
  - `ptr` = 0.
  - `s1_valid` = `s2_valid` = 0.
  - `out_pm` = 0, `out_po` = 0, `out_ps` = 0, `out_tag` = 0, `done_count` = 0.
  - `req_ready` = 0 while `reset` is high.
- **Reset mid-operation.** Any in-flight S1 or S2 contents are discarded without a response, and `done_count` clears.
- **Latency.** A pair accepted at edge k appears with `out_valid` = 1 after edge k+1, provided S2 is free.
- **Throughput.** With `out_ready` held at 1 and requests available, one result per cycle. The first result takes 2 edges.
- **Full condition.** S1 and S2 both valid and `out_ready` = 0. All `req_ready` bits are 0. At most 2 transactions are buffered.
- **Simultaneous events.** If `out_ready` = 1 with both stages full, three things happen on the same edge:
  - the S2 result is consumed,
  - S1 moves to S2,
  - a new request is granted into S1.
- **Idle.** With no `req_valid` bits set, the pipeline drains. `out_valid` drops after the last result is consumed.

## Test plan

- **Single op, normal operands.** Reset, then requester 0 sends x=4'b0010, y=4'b0011. Required: `out_valid` one cycle after acceptance with pm=4'b0110, po=3'b010, ps=0, tag=0, and `done_count`=1 after consumption.
- **Denormal operand and sign.** Requester 2 sends x=4'b1111, y=4'b0001. Required: pm=4'b0110, po=3'b011, ps=1, tag=2. Separately, x=4'b0001 with y=4'b0001 must give pm=4'b1001, po=3'b000, ps=0.
- **Round-robin fairness.** All 4 `req_valid` bits held high with `out_ready`=1. Required: grants and `out_tag` sequence 0,1,2,3,0,1 with one grant per cycle. Then with only bits 1 and 3 high, the sequence must alternate 1,3,1,3.
- **Backpressure.** Continuous requests with `out_ready`=0. Required: exactly 2 grants, after which `req_ready` stays at 0 and the S2 outputs stay stable. Raising `out_ready` must then deliver both results in order, with no loss and no duplication.
- **Reset mid-flight.** Assert `reset` with both stages full. Required: the next cycle shows `out_valid`=0, `done_count`=0 and `ptr`=0, so the first grant after reset goes to requester 0 when all requesters are valid.
- **Counter wrap.** With CW=2, complete 5 operations. Required: `done_count` reads 1.
